// File: rtl/pc_pkg.sv
// pc_pkg: types and defaults shared by the program-counter stage and the control unit.
//   PC_WIDTH      - default instruction-address width
//   PC_RESET_ADDR - default PC value after reset
//   pc_cmd_e      - resolved PC command, one per enabled cycle
//   pc_decode     - priority decode ret > call > jmp > increment, gated by en
package pc_pkg;

  localparam int unsigned PC_WIDTH      = 9;
  localparam int unsigned PC_RESET_ADDR = 0;

  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_JMP  = 3'd2,
    PC_CALL = 3'd3,
    PC_RET  = 3'd4
  } pc_cmd_e;

  // Lower-priority strobes asserted in the same cycle are simply dropped.
  function automatic pc_cmd_e pc_decode(input logic en, input logic jmp,
                                        input logic call, input logic ret);
    pc_cmd_e cmd;
    cmd = PC_HOLD;
    if (en) begin
      if (ret)       cmd = PC_RET;
      else if (call) cmd = PC_CALL;
      else if (jmp)  cmd = PC_JMP;
      else           cmd = PC_INC;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/pc_unit_ret_stack.sv
// ret_stack: DEPTH x WIDTH LIFO holding subroutine return addresses.
//   clk, rst       - clock, async active-high reset (clears the count only)
//   i_push, i_din  - push i_din when not full
//   i_pop          - pop top entry when not empty (push wins if both are set)
//   o_top          - current top entry, valid while not empty
//   o_full/o_empty - status derived from the registered count
//   o_count        - number of valid entries
module ret_stack #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [WIDTH-1:0]             i_din,
  output logic [WIDTH-1:0]             o_top,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_top_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty && !i_push;
  // Count is below DEPTH whenever a push happens, so truncation is exact.
  assign w_wr_idx  = AW'(r_count);
  assign w_top_idx = AW'(r_count - CW'(1));
  assign o_top     = r_mem[w_top_idx];
  assign o_count   = r_count;

  // Entry count; contents are never cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_do_push) begin
      r_count <= r_count + CW'(1);
    end else if (w_do_pop) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Storage, no reset needed.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_din;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter stage; registered instruction address for the
// address multiplexor's sequential input, with optional return-address stack.
//   clk, rst   - clock, async active-high reset
//   en         - advance strobe (0 = full stall)
//   jmp/call/ret, jmpAddr - control-unit commands, priority ret > call > jmp > inc
//   pcOUT      - current PC (registered)
//   spDepth    - valid return-stack entries
//   stackErr   - sticky overflow/underflow flag, cleared only by rst
// Macro PC_RET_STACK_EN: when defined, the return stack is built; otherwise call
// acts as jmp, ret holds, and spDepth/stackErr are tied to 0.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH      = PC_WIDTH,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RESET_ADDR = PC_RESET_ADDR
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        jmp,
  input  logic                        call,
  input  logic                        ret,
  input  logic [WIDTH-1:0]            jmpAddr,
  output logic [WIDTH-1:0]            pcOUT,
  output logic [$clog2(DEPTH+1)-1:0]  spDepth,
  output logic                        stackErr
);

  localparam int unsigned SPW = $clog2(DEPTH+1);

  pc_cmd_e          w_cmd;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_pc_next;

  assign w_cmd    = pc_decode(en, jmp, call, ret);
  assign w_pc_inc = r_pc + WIDTH'(1);
  assign pcOUT    = r_pc;

`ifdef PC_RET_STACK_EN
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_top;
  logic [SPW-1:0]   w_count;
  logic             w_err_set;
  logic             r_stack_err;

  assign w_push    = (w_cmd == PC_CALL) && !w_full;
  assign w_pop     = (w_cmd == PC_RET) && !w_empty;
  assign w_err_set = ((w_cmd == PC_CALL) && w_full) ||
                     ((w_cmd == PC_RET) && w_empty);

  ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_pc_inc),
    .o_top   (w_top),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Next-PC mux; an underflowing ret holds the PC rather than incrementing.
  always_comb begin
    w_pc_next = r_pc;
    case (w_cmd)
      PC_INC:  w_pc_next = w_pc_inc;
      PC_JMP:  w_pc_next = jmpAddr;
      PC_CALL: w_pc_next = jmpAddr;
      PC_RET:  if (!w_empty) w_pc_next = w_top;
      default: w_pc_next = r_pc;
    endcase
  end

  // Sticky stack error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stack_err <= 1'b0;
    end else if (w_err_set) begin
      r_stack_err <= 1'b1;
    end
  end

  assign spDepth  = w_count;
  assign stackErr = r_stack_err;
`else
  // Without the stack, call is a plain jump and ret is a hold.
  always_comb begin
    w_pc_next = r_pc;
    case (w_cmd)
      PC_INC:  w_pc_next = w_pc_inc;
      PC_JMP:  w_pc_next = jmpAddr;
      PC_CALL: w_pc_next = jmpAddr;
      default: w_pc_next = r_pc;
    endcase
  end

  assign spDepth  = SPW'(0);
  assign stackErr = 1'b0;
`endif

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= WIDTH'(RESET_ADDR);
    end else begin
      r_pc <= w_pc_next;
    end
  end

endmodule
